// File: rtl/tx_sequencer.sv
// Burst sequencer: N_FLUSH warm-up strobes, then i_len counted symbol strobes spaced i_div+1 cycles apart.
// Latency: first strobe div+1 cycles after FLUSH entry; o_done one cycle after the final strobe.
// Backpressure: none; i_abort ends a burst on the next edge, and i_start is ignored while busy.
module tx_sequencer #(
    parameter int NB_DIV  = 3,
    parameter int NB_LEN  = 16,
    parameter int N_FLUSH = 8
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [NB_DIV-1:0] i_div,
    input  logic [NB_LEN-1:0] i_len,
    output logic              o_valid,
    output logic              o_prbs_en,
    output logic              o_fir_en,
    output logic              o_busy,
    output logic              o_done,
    output logic [NB_LEN-1:0] o_sym_count,
    output logic [1:0]        o_state
);

    localparam int NB_FL = (N_FLUSH < 2) ? 1 : $clog2(N_FLUSH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NB_DIV-1:0] div_q, div_cnt;
    logic [NB_LEN-1:0] len_q, sym_cnt;
    logic [NB_FL-1:0]  flush_cnt;
    logic              active, strobe, accept, flush_last, sym_last;

    assign active     = (state_q == ST_FLUSH) || (state_q == ST_RUN);
    assign strobe     = active && (div_cnt == div_q);
    assign accept     = (state_q == ST_IDLE) && i_start && !i_abort;
    assign flush_last = (flush_cnt == NB_FL'(N_FLUSH - 1));
    assign sym_last   = ((sym_cnt + NB_LEN'(1)) == len_q);

    always_comb begin
        state_d   = state_q;
        o_valid   = strobe;
        o_prbs_en = active;
        o_fir_en  = active;
        o_busy    = (state_q != ST_IDLE);
        o_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = (i_len == '0) ? ST_DONE : ST_FLUSH;
            end
            ST_FLUSH: begin
                if (i_abort)                   state_d = ST_IDLE;
                else if (strobe && flush_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_abort)                 state_d = ST_IDLE;
                else if (strobe && sym_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                // An abort landing on the DONE cycle swallows the pulse.
                o_done  = !i_abort;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            div_q     <= '0;
            len_q     <= '0;
            div_cnt   <= '0;
            flush_cnt <= '0;
            sym_cnt   <= '0;
        end else if (accept) begin
            div_q     <= i_div;
            len_q     <= i_len;
            div_cnt   <= '0;
            flush_cnt <= '0;
            sym_cnt   <= '0;
        end else if (active) begin
            // Divider free-runs across FLUSH->RUN so symbol spacing stays uniform.
            div_cnt <= strobe ? '0 : div_cnt + NB_DIV'(1);
            if (strobe && state_q == ST_FLUSH)
                flush_cnt <= flush_last ? '0 : flush_cnt + NB_FL'(1);
            if (strobe && state_q == ST_RUN && !i_abort)
                sym_cnt <= sym_cnt + NB_LEN'(1);
        end
    end

    assign o_sym_count = sym_cnt;
    assign o_state     = state_q;

endmodule

// File: tb/tb_tx_sequencer.sv
// Randomized bench for tx_sequencer against a burst-schedule model (strobe k of a burst at start+k*(div+1)).
module tb_tx_sequencer;

    localparam int NB_DIV  = 3;
    localparam int NB_LEN  = 16;
    localparam int N_FLUSH = 8;

    logic              clock = 1'b0;
    logic              i_reset, i_start, i_abort;
    logic [NB_DIV-1:0] i_div;
    logic [NB_LEN-1:0] i_len;
    logic              o_valid, o_prbs_en, o_fir_en, o_busy, o_done;
    logic [NB_LEN-1:0] o_sym_count;
    logic [1:0]        o_state;

    int checks   = 0;
    int failures = 0;

    // Model state: burst in progress, its start cycle and latched parameters.
    int cyc    = 0;
    bit active = 0;
    int t0     = 0;
    int m_div  = 0;
    int m_len  = 0;
    int held   = 0;

    tx_sequencer #(.NB_DIV(NB_DIV), .NB_LEN(NB_LEN), .N_FLUSH(N_FLUSH)) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_div       (i_div),
        .i_len       (i_len),
        .o_valid     (o_valid),
        .o_prbs_en   (o_prbs_en),
        .o_fir_en    (o_fir_en),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_sym_count (o_sym_count),
        .o_state     (o_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model across the rising edge.
    task automatic step(input bit rst, input bit st, input bit ab, input int dv, input int ln);
        int e, p, end_e, ex_state, ex_valid, ex_done, ex_sym, ex_en;
        i_reset = rst;
        i_start = st;
        i_abort = ab;
        i_div   = NB_DIV'(dv);
        i_len   = NB_LEN'(ln);
        #1;
        ex_state = 0;
        ex_valid = 0;
        ex_done  = 0;
        ex_sym   = held;
        if (active) begin
            e     = cyc - t0;
            p     = m_div + 1;
            end_e = (m_len == 0) ? 0 : (N_FLUSH + m_len) * p;
            if (e <= end_e) begin
                ex_state = (e <= N_FLUSH * p) ? 1 : 2;
                ex_valid = (e % p == 0) ? 1 : 0;
                ex_sym   = (e - 1) / p - N_FLUSH;
                if (ex_sym < 0) ex_sym = 0;
            end else begin
                ex_state = 3;
                ex_done  = ab ? 0 : 1;
                ex_sym   = m_len;
            end
        end
        ex_en = (ex_state == 1 || ex_state == 2) ? 1 : 0;
        chk("state",     int'(o_state),     ex_state);
        chk("valid",     int'(o_valid),     ex_valid);
        chk("prbs_en",   int'(o_prbs_en),   ex_en);
        chk("fir_en",    int'(o_fir_en),    ex_en);
        chk("busy",      int'(o_busy),      (ex_state != 0) ? 1 : 0);
        chk("done",      int'(o_done),      ex_done);
        chk("sym_count", int'(o_sym_count), ex_sym);

        if (rst) begin
            active = 0;
            held   = 0;
        end else if (active) begin
            if (ab || ex_state == 3) begin
                active = 0;
                held   = ex_sym;
            end
        end else if (st && !ab) begin
            active = 1;
            t0     = cyc;
            m_div  = dv;
            m_len  = ln;
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 9));
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_div   = '0;
        i_len   = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);

        // Reset state, then the documented bursts.
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 3);  idle(15);
        step(0, 1, 0, 3, 2);  idle(45);
        step(0, 1, 0, 2, 0);  idle(4);
        // Abort after 4 RUN symbols at div=0.
        step(0, 1, 0, 0, 10); idle(12);
        step(0, 0, 1, 0, 0);  idle(3);
        // Start and abort together in IDLE.
        step(0, 1, 1, 1, 4);  idle(3);
        // Start held high throughout a burst.
        step(0, 1, 0, 0, 5);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 7, 9);
        idle(4);
        // Reset mid-FLUSH followed by a clean burst.
        step(0, 1, 0, 1, 2);  idle(5);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 2);  idle(30);

        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 59) == 0),
                 $urandom_range(0, 3),
                 $urandom_range(0, 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_sequencer.md
TX_SEQUENCER -- requirements
Module: tx_sequencer

Interface
REQ-001 Parameters SHALL be:
- NB_DIV, default 3: width of the strobe-period field.
- NB_LEN, default 16: width of the burst-length field and symbol counter.
- N_FLUSH, default 8: warm-up strobes issued before counted symbols.

REQ-002 Ports SHALL be:
- clock  in  1  single clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  burst request; sampled only in IDLE.
- i_abort  in  1  terminate the burst.
- i_div  in  NB_DIV  strobe period minus 1.
- i_len  in  NB_LEN  number of counted symbols in the burst.
- o_valid  out  1  one-cycle symbol strobe to the PRBS and FIR valid inputs.
- o_prbs_en  out  1  PRBS enable.
- o_fir_en  out  1  FIR enable.
- o_busy  out  1  high when state is not IDLE.
- o_done  out  1  one-cycle burst-complete pulse.
- o_sym_count  out  NB_LEN  counted RUN strobes.
- o_state  out  2  IDLE=0, FLUSH=1, RUN=2, DONE=3.

Function
REQ-003 The FSM SHALL have four states: IDLE, FLUSH, RUN, DONE.

REQ-004 IDLE with i_start=1 and i_abort=0 SHALL:
- latch i_div into div_q and i_len into len_q;
- clear o_sym_count, the strobe counter and the divider;
- go to DONE if i_len==0, otherwise to FLUSH.

REQ-005 The divider SHALL count 0..div_q, wrapping to 0 on the cycle after reaching div_q.
- It runs only in FLUSH and RUN and does not restart at the FLUSH->RUN transition.

REQ-006 o_valid SHALL equal 1 exactly when the state is FLUSH or RUN and divider==div_q.
- div_q=0 gives a strobe every cycle.
- The first strobe occurs div_q+1 cycles after entering FLUSH.

REQ-007 In FLUSH, strobes SHALL be counted in a flush counter.
- The cycle after the N_FLUSH-th strobe the state SHALL be RUN, with the flush counter cleared.
- FLUSH strobes SHALL NOT increment o_sym_count.

REQ-008 In RUN, each o_valid SHALL increment o_sym_count.
- The cycle after the strobe that brings o_sym_count to len_q the state SHALL be DONE.

REQ-009 DONE SHALL last exactly one cycle with o_done=1, then go to IDLE.

REQ-010 o_prbs_en and o_fir_en SHALL be 1 in FLUSH and RUN, and 0 in IDLE and DONE.

REQ-011 i_abort=1 in FLUSH, RUN or DONE SHALL force IDLE on the next cycle.
- No o_done pulse SHALL be produced, or the pending one is suppressed.
- o_sym_count SHALL hold its partial value.

REQ-012 Input precedence:
- i_abort and i_start together in IDLE: abort wins, state remains IDLE.
- i_start outside IDLE SHALL be ignored.

REQ-013 Changes to i_div and i_len after the start SHALL NOT affect the running burst.

REQ-014 o_sym_count SHALL hold its final value through DONE and IDLE until the next accepted i_start.
- The NB_LEN counter never wraps within a burst, because len_q bounds it.

REQ-015 o_busy SHALL equal (state != IDLE); o_state SHALL reflect the registered state.

Reset
REQ-016 When i_reset=1 at a clock edge, the next cycle SHALL show:
- state IDLE;
- o_valid, o_prbs_en, o_fir_en, o_busy and o_done all 0;
- o_sym_count, divider, flush counter, div_q and len_q all 0.

REQ-017 i_reset SHALL override i_start and i_abort, including mid-FLUSH and mid-RUN.

Verification
REQ-018 div=0, len=3, start sampled at cycle 0:
- FLUSH in cycles 1-8 with o_valid every cycle;
- RUN in cycles 9-11 with o_valid, o_sym_count reaching 3;
- o_done=1 in cycle 12; IDLE in cycle 13.

REQ-019 div=3, len=2, start at cycle 0:
- o_valid at cycles 4, 8, ..., 32 (FLUSH) and at 36, 40 (RUN);
- o_done in cycle 41; no o_valid in any other cycle.

REQ-020 len=0, start at cycle 0:
- DONE with o_done=1 in cycle 1; IDLE in cycle 2;
- o_valid, o_prbs_en and o_fir_en never asserted.

REQ-021 div=0, len=10, i_abort during RUN after 4 symbols:
- IDLE next cycle with all enables at 0;
- o_sym_count=4; no o_done pulse.

REQ-022 Precedence checks:
- i_start and i_abort in the same IDLE cycle: remains IDLE.
- i_start pulsed during RUN: no effect on the burst.
- i_reset mid-FLUSH: all outputs 0 next cycle; a new start afterwards runs normally.
